// File: rtl/iter_pkg.sv
// Shared types and constants for the iterative job sequencer.
// Sequencer state encodings, default operand width, job counter width.
package iter_pkg;

    localparam int W_DEF  = 16;
    localparam int JOB_CW = 16;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_START = 2'd1,
        SEQ_RUN   = 2'd2,
        SEQ_EMIT  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/iter_job_sequencer_if.sv
// Operand-in / result-out valid-ready streams of the job sequencer.
// slave is the sequencer side, master is the producer/consumer side.
interface iter_job_sequencer_if
    import iter_pkg::*;
#(
    parameter int W = W_DEF
);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_tmo;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_tmo
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_tmo
    );

endinterface

// File: rtl/iter_job_sequencer_fifo.sv
// Operand FIFO with combinational head; pointers carry a wrap bit.
// Pushes are refused when full, even if a pop happens in the same cycle.
module sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_q;
    logic [AW:0]  rd_q;
    logic         wr_en;
    logic         rd_en;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW])
                && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign dout  = mem[rd_q[AW-1:0]];
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + (AW+1)'(1);
            if (rd_en) rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/iter_job_sequencer.sv
// Wraps an iterative core: queues operands, runs one job per operand,
// guards each job with a cycle watchdog and streams results out.
module iter_job_sequencer
    import iter_pkg::*;
#(
    parameter int W          = W_DEF,
    parameter int DEPTH      = 4,
    parameter int MAX_CYCLES = 255
) (
    input  logic                clock,
    input  logic                reset,
    iter_job_sequencer_if.slave bus,
    output logic                core_rst,
    output logic [W-1:0]        core_x,
    input  logic                core_read,
    input  logic                core_done,
    input  logic [W-1:0]        core_y,
    output logic                proto_err,
    output logic                busy,
    output logic [JOB_CW-1:0]   job_count
);

    localparam int CW = $clog2(MAX_CYCLES + 1);

    seq_state_t        state_q;
    seq_state_t        state_d;
    logic              ready_q;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [W-1:0]      head;
    logic [W-1:0]      x_q;
    logic [CW-1:0]     wd_q;
    logic [CW-1:0]     wd_inc;
    logic              wd_hit;
    logic              seen_q;
    logic              perr_q;
    logic [W-1:0]      out_data_q;
    logic              tmo_q;
    logic              hs;
    logic [JOB_CW-1:0] job_count_q;

    sync_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (bus.in_data),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // ready_q keeps in_ready low for the first cycle after reset
    assign bus.in_ready  = ready_q & ~full;
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = (state_q == SEQ_IDLE) & ~empty;
    assign bus.out_valid = (state_q == SEQ_EMIT);
    assign bus.out_data  = out_data_q;
    assign bus.out_tmo   = tmo_q;
    assign hs            = bus.out_valid & bus.out_ready;
    assign core_rst      = reset | (state_q == SEQ_START);
    assign core_x        = x_q;
    assign proto_err     = perr_q;
    assign busy          = (state_q != SEQ_IDLE) | ~empty;
    assign job_count     = job_count_q;

    // wd_inc counts the current RUN cycle, so MAX_CYCLES cycles run
    assign wd_inc = wd_q + CW'(1);
    assign wd_hit = (wd_inc == CW'(MAX_CYCLES));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SEQ_IDLE:  if (!empty) state_d = SEQ_START;
            SEQ_START: state_d = SEQ_RUN;
            SEQ_RUN:   if (core_done || wd_hit) state_d = SEQ_EMIT;
            SEQ_EMIT:  if (bus.out_ready) state_d = SEQ_IDLE;
            default:   state_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= SEQ_IDLE;
            ready_q <= 1'b0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= 1'b1;
            if (pop) x_q <= head;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_q   <= '0;
            seen_q <= 1'b0;
            perr_q <= 1'b0;
        end else if (state_q == SEQ_START) begin
            wd_q   <= '0;
            seen_q <= 1'b0;
        end else if (state_q == SEQ_RUN) begin
            wd_q <= wd_inc;
            if (core_read) begin
                seen_q <= 1'b1;
                if (seen_q) perr_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_data_q <= '0;
            tmo_q      <= 1'b0;
        end else if (state_q == SEQ_RUN) begin
            if (core_done) begin
                out_data_q <= core_y;
                tmo_q      <= 1'b0;
            end else if (wd_hit) begin
                out_data_q <= '0;
                tmo_q      <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            job_count_q <= '0;
        end else if (hs) begin
            job_count_q <= job_count_q + JOB_CW'(1);
        end
    end

endmodule
